// File: rtl/expr_pipe_pkg.sv
// expr_pipe_pkg: opcode encoding and compare-range helper shared by the expression pipeline
package expr_pipe_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_SHL,
    OP_SHR, OP_ASHR, OP_LT, OP_GE, OP_EQ, OP_NE, OP_MIN, OP_MAX
  } op_e;
  localparam logic [3:0] OP_CMP_LO = 4'd10;
  localparam logic [3:0] OP_CMP_HI = 4'd13;
  function automatic logic is_cmp(input logic [3:0] op);
    return op >= OP_CMP_LO && op <= OP_CMP_HI;
  endfunction
endpackage

// File: rtl/expr_lane_alu.sv
// expr_lane_alu: one combinational lane on operands pre-extended to W+1 bits by their own signedness
module expr_lane_alu
  import expr_pipe_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W:0]   ext_a,
  input  logic [W:0]   ext_b,
  input  logic         sgn,
  input  logic [3:0]   op,
  output logic [W-1:0] res,
  output logic         flag
);
  logic [W-1:0] a, b;
  logic [W:0] ca, cb, sh;
  logic big, lt;
  assign a = ext_a[W-1:0];
  assign b = ext_b[W-1:0];
  assign ca = sgn ? ext_a : {1'b0, a};
  assign cb = sgn ? ext_b : {1'b0, b};
  assign lt = $signed(ca) < $signed(cb);
  assign big = int'(b) >= W;
  assign sh = $signed(ext_a) >>> b;
  always_comb begin
    res = '0;
    flag = 1'b0;
    case (op_e'(op))
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_SHL:  res = big ? '0 : a << b;
      OP_SHR:  res = big ? '0 : a >> b;
      OP_ASHR: res = big ? {W{ext_a[W]}} : sh[W-1:0];
      OP_LT:   flag = lt;
      OP_GE:   flag = !lt;
      OP_EQ:   flag = a == b;
      OP_NE:   flag = a != b;
      OP_MIN:  res = lt ? a : b;
      OP_MAX:  res = lt ? b : a;
      default: res = '0;
    endcase
    if (is_cmp(op)) res = {{(W-1){1'b0}}, flag};
  end
endmodule

// File: rtl/expr_pipe_eval.sv
// expr_pipe_eval: two-stage valid/ready lane evaluator; EXPR_PIPE_SIG_EN enables the output signature
module expr_pipe_eval
  import expr_pipe_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int NCH   = 6,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       op,
  input  logic [NCH*WIDTH-1:0] a,
  input  logic [NCH*WIDTH-1:0] b,
  input  logic [NCH-1:0]       a_sgn,
  input  logic [NCH-1:0]       b_sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] y,
  output logic [NCH-1:0]       cmp_flag,
  output logic [CNTW-1:0]      txn_cnt,
  output logic [WIDTH-1:0]     sig
);
  localparam int EW = WIDTH + 1;
  logic s1_valid, s2_valid, s2_adv;
  logic [NCH*EW-1:0] ea, eb, s1_a, s1_b;
  logic [NCH-1:0] s1_sgn, lane_flag;
  logic [OPW-1:0] s1_op;
  logic [NCH*WIDTH-1:0] lane_res;
  assign s2_adv = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign out_valid = s2_valid;
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign ea[i*EW +: EW] = {a_sgn[i] & a[i*WIDTH+WIDTH-1], a[i*WIDTH +: WIDTH]};
    assign eb[i*EW +: EW] = {b_sgn[i] & b[i*WIDTH+WIDTH-1], b[i*WIDTH +: WIDTH]};
    expr_lane_alu #(.W(WIDTH)) u_alu (
      .ext_a(s1_a[i*EW +: EW]),
      .ext_b(s1_b[i*EW +: EW]),
      .sgn  (s1_sgn[i]),
      .op   (s1_op),
      .res  (lane_res[i*WIDTH +: WIDTH]),
      .flag (lane_flag[i])
    );
  end
  always_ff @(posedge clk)
    if (reset) s1_valid <= 1'b0;
    else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= ea;
        s1_b <= eb;
        s1_sgn <= a_sgn & b_sgn;
        s1_op <= op;
      end
    end
  always_ff @(posedge clk)
    if (reset) begin
      s2_valid <= 1'b0;
      y <= '0;
      cmp_flag <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y <= lane_res;
        cmp_flag <= lane_flag;
      end
    end
  always_ff @(posedge clk)
    if (reset) txn_cnt <= '0;
    else if (out_valid && out_ready) txn_cnt <= txn_cnt + 1'b1;
`ifdef EXPR_PIPE_SIG_EN
  logic [WIDTH-1:0] y_x;
  always_comb begin
    y_x = '0;
    for (int j = 0; j < NCH; j++) y_x ^= y[j*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk)
    if (reset) sig <= '0;
    else if (out_valid && out_ready) sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ y_x;
`else
  assign sig = '0;
`endif
endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb_expr_pipe_eval: random and directed stimulus against an integer-arithmetic lane model and scoreboard
module tb_expr_pipe_eval;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op;
  logic [35:0] a, b, y;
  logic [5:0] a_sgn, b_sgn, cmp_flag, sig;
  logic [15:0] txn_cnt;
  int n_chk, n_fail, acc_cnt;
  logic [15:0] exp_cnt;
  logic [5:0] exp_sig;
  logic [35:0] q_y[$];
  logic [5:0] q_f[$];
  logic [35:0] bp_a[4], bp_b[4];
  logic [3:0] bp_op[4];
  logic [5:0] bp_as[4], bp_bs[4];
  expr_pipe_eval dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .a_sgn(a_sgn), .b_sgn(b_sgn), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .cmp_flag(cmp_flag), .txn_cnt(txn_cnt), .sig(sig)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] ref_lane(input logic [3:0] o, input logic [5:0] x, input logic [5:0] z,
                                          input logic xs, input logic zs);
    int va, vb, fa;
    logic [5:0] r;
    logic f;
    va = (xs && zs && x[5]) ? int'(x) - 64 : int'(x);
    vb = (xs && zs && z[5]) ? int'(z) - 64 : int'(z);
    fa = (xs && x[5]) ? int'(x) - 64 : int'(x);
    r = 6'd0;
    f = 1'b0;
    case (o)
      4'd0: r = 6'(va + vb);
      4'd1: r = 6'(va - vb);
      4'd2: r = 6'(va * vb);
      4'd3: r = x & z;
      4'd4: r = x | z;
      4'd5: r = x ^ z;
      4'd6: r = ~(x ^ z);
      4'd7: r = (int'(z) >= 6) ? 6'd0 : 6'(int'(x) << z);
      4'd8: r = (int'(z) >= 6) ? 6'd0 : x >> z;
      4'd9: r = (int'(z) >= 6) ? ((fa < 0) ? 6'h3f : 6'h00) : 6'(fa >>> z);
      4'd10: f = va < vb;
      4'd11: f = va >= vb;
      4'd12: f = va == vb;
      4'd13: f = va != vb;
      4'd14: r = 6'(va < vb ? va : vb);
      default: r = 6'(va < vb ? vb : va);
    endcase
    if (o >= 4'd10 && o <= 4'd13) r = {5'b0, f};
    return {f, r};
  endfunction
  task automatic tick();
    logic ih, oh, hold;
    logic [35:0] ey, yh;
    logic [5:0] ef;
    logic [6:0] r7;
    #1;
    ih = in_valid & in_ready;
    oh = out_valid & out_ready;
    hold = out_valid & !out_ready;
    yh = y;
    if (oh) begin
      if (q_y.size() == 0) check("sb_underflow", 1, 0);
      else begin
        ey = q_y.pop_front();
        ef = q_f.pop_front();
        check("y", y, ey);
        check("cmp_flag", cmp_flag, ef);
`ifdef EXPR_PIPE_SIG_EN
        exp_sig = {exp_sig[4:0], exp_sig[5]};
        for (int i = 0; i < 6; i++) exp_sig ^= ey[i*6 +: 6];
`endif
      end
      exp_cnt++;
    end
    if (ih) begin
      for (int i = 0; i < 6; i++) begin
        r7 = ref_lane(op, a[i*6 +: 6], b[i*6 +: 6], a_sgn[i], b_sgn[i]);
        ey[i*6 +: 6] = r7[5:0];
        ef[i] = r7[6];
      end
      q_y.push_back(ey);
      q_f.push_back(ef);
      acc_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    check("txn_cnt", txn_cnt, exp_cnt);
    check("sig", sig, exp_sig);
    if (hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_y", y, yh);
    end
  endtask
  task automatic rand_in(input logic [3:0] o);
    op = o;
    a = 36'({$urandom, $urandom});
    for (int i = 0; i < 6; i++) b[i*6 +: 6] = $urandom_range(1) ? 6'($urandom_range(7)) : 6'($urandom);
    a_sgn = 6'($urandom);
    b_sgn = 6'($urandom);
  endtask
  task automatic one(input string tag, input logic [3:0] o, input logic [5:0] a0, input logic [5:0] b0,
                     input logic as0, input logic bs0, input logic [5:0] ey0, input logic ef0);
    rand_in(o);
    a[5:0] = a0;
    b[5:0] = b0;
    a_sgn[0] = as0;
    b_sgn[0] = bs0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    check({tag, "_lat1"}, out_valid, 0);
    in_valid = 1'b0;
    tick();
    check({tag, "_lat2"}, out_valid, 1);
    check(tag, y[5:0], ey0);
    check({tag, "_flag"}, cmp_flag[0], ef0);
    tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_y.delete();
    q_f.delete();
    exp_cnt = '0;
    exp_sig = '0;
    acc_cnt = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1);
  end
  initial begin
    n_chk = 0;
    n_fail = 0;
    acc_cnt = 0;
    exp_cnt = '0;
    exp_sig = '0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    a_sgn = '0;
    b_sgn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_txn_cnt", txn_cnt, 0);
    check("rst_y", y, 0);
    check("rst_cmp", cmp_flag, 0);
    check("rst_sig", sig, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    one("add", 4'd0, 6'h3D, 6'h05, 1, 1, 6'h02, 0);
    one("lt_u", 4'd10, 6'h3F, 6'h01, 1, 0, 6'h00, 0);
    one("lt_s", 4'd10, 6'h3F, 6'h01, 1, 1, 6'h01, 1);
    one("ashr_s", 4'd9, 6'h30, 6'h02, 1, 0, 6'h3C, 0);
    one("ashr_u", 4'd9, 6'h30, 6'h02, 0, 1, 6'h0C, 0);
    one("ashr_big", 4'd9, 6'h30, 6'h07, 1, 0, 6'h3F, 0);
    one("mul_7x9", 4'd2, 6'h07, 6'h09, 0, 0, 6'h3F, 0);
    one("mul_8x8", 4'd2, 6'h08, 6'h08, 0, 0, 6'h00, 0);
    one("shl_big", 4'd7, 6'h01, 6'h06, 0, 0, 6'h00, 0);
    one("shr_5", 4'd8, 6'h20, 6'h05, 1, 1, 6'h01, 0);
    one("min_u", 4'd14, 6'h3F, 6'h01, 1, 0, 6'h01, 0);
    one("min_s", 4'd14, 6'h3F, 6'h01, 1, 1, 6'h3F, 0);
    one("ge_s", 4'd11, 6'h20, 6'h1F, 1, 1, 6'h00, 0);
    one("ge_u", 4'd11, 6'h20, 6'h1F, 1, 0, 6'h01, 1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bp_op[k] = 4'($urandom);
      bp_a[k] = 36'({$urandom, $urandom});
      bp_a[k][5:0] = 6'(k + 1);
      bp_b[k] = 36'({$urandom, $urandom});
      bp_as[k] = 6'($urandom);
      bp_bs[k] = 6'($urandom);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      op = bp_op[acc_cnt];
      a = bp_a[acc_cnt];
      b = bp_b[acc_cnt];
      a_sgn = bp_as[acc_cnt];
      b_sgn = bp_bs[acc_cnt];
      tick();
    end
    check("bp_accepted", acc_cnt, 2);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_cnt != 16'd4; c++) begin
      in_valid = acc_cnt < 4;
      if (acc_cnt < 4) begin
        op = bp_op[acc_cnt];
        a = bp_a[acc_cnt];
        b = bp_b[acc_cnt];
        a_sgn = bp_as[acc_cnt];
        b_sgn = bp_bs[acc_cnt];
      end
      tick();
    end
    check("bp_drained", q_y.size(), 0);
    check("bp_txn_cnt", txn_cnt, 16'd4);
    for (int c = 0; c < 2; c++) begin
      rand_in(4'($urandom));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_txn_cnt", txn_cnt, 0);
    check("midrst_sig", sig, 0);
    reset = 1'b0;
    q_y.delete();
    q_f.delete();
    exp_cnt = '0;
    exp_sig = '0;
    tick();
    tick();
    check("midrst_no_output", out_valid, 0);
    for (int c = 0; c < 400; c++) begin
      rand_in(4'($urandom));
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(3) != 0;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q_y.size() != 0; c++) tick();
    check("final_drain", q_y.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
